// File: rtl/pc_select_unit.sv
// Program-counter stage: holds the fetch PC, selects the next address and keeps
// a circular return-address stack that predicts register returns.
module pc_select_unit #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jump_reg,
  input  logic [WIDTH-1:0] reg_target,
  input  logic             link,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             mispredict,
  output logic             misaligned
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(1) << ALIGN_BITS;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP - WIDTH'(1));
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic             mispredict_q, mispredict_d;
  logic             misaligned_q, misaligned_d;
  logic [WIDTH-1:0] target;

  assign pc         = pc_q;
  assign pc_plus    = pc_q + STEP;
  assign ras_empty  = (count_q == '0);
  assign ras_full   = (count_q == CNT_MAX);
  assign ras_top    = ras_empty ? '0 : ras_q[top_q];
  assign mispredict = mispredict_q;
  assign misaligned = misaligned_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    pc_d         = pc_q;
    top_d        = top_q;
    count_d      = count_q;
    ras_d        = ras_q;
    mispredict_d = 1'b0;
    misaligned_d = 1'b0;

    if (jump_reg)          target = reg_target;
    else if (jump)         target = jump_target;
    else if (branch_taken) target = branch_target;
    else                   target = pc_plus;

    if (!stall) begin
      pc_d         = target & ALIGN_MASK;
      misaligned_d = |(target & ~ALIGN_MASK);
      // Prediction is judged against the stack as it stood before this cycle's update.
      mispredict_d = ret && jump_reg && (ras_empty || (ras_top != reg_target));

      if (link && ret) begin
        ras_d[top_q] = pc_plus;
      end else if (link) begin
        top_d        = top_q + PTR_W'(1);
        ras_d[top_d] = pc_plus;
        if (!ras_full) count_d = count_q + CNT_W'(1);
      end else if (ret && !ras_empty) begin
        top_d   = top_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      top_q        <= '0;
      count_q      <= '0;
      mispredict_q <= 1'b0;
      misaligned_q <= 1'b0;
      // NOTE: the stack entries are reset too, so no stale return address survives a reset.
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q         <= pc_d;
      top_q        <= top_d;
      count_q      <= count_d;
      mispredict_q <= mispredict_d;
      misaligned_q <= misaligned_d;
      ras_q        <= ras_d;
    end
  end

endmodule

// File: doc/pc_select_unit.md
# pc_select_unit

Parametrised program-counter stage for the single-cycle core: it holds the PC register and chooses the next fetch address. Sources are the sequential address, a taken branch, an absolute jump, and a register jump. It adds synchronous reset to a configurable vector, stall, alignment checking and a circular return-address stack (RAS) that predicts register returns and flags mispredictions. It sits between the control unit and instruction memory, and its `pc` output drives fetch directly.

## Interface
Parameters:
- WIDTH, 32, address width in bits (≥ 8)
- RESET_VECTOR, 0, PC value loaded on reset; must be aligned
- RAS_DEPTH, 4, return-stack entries; power of two, ≥ 2
- ALIGN_BITS, 2, low address bits that must be zero (instruction size 2^ALIGN_BITS bytes)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold PC and RAS this cycle
- branch_taken  in  1  select branch_target
- branch_target  in  WIDTH  branch destination
- jump  in  1  select jump_target
- jump_target  in  WIDTH  absolute jump destination
- jump_reg  in  1  select reg_target
- reg_target  in  WIDTH  register-file jump destination
- link  in  1  push return address (pc_plus) onto RAS
- ret  in  1  current jump_reg is a return; pop RAS
- pc  out  WIDTH  current fetch address (registered)
- pc_plus  out  WIDTH  pc + 2^ALIGN_BITS, combinational, wraps modulo 2^WIDTH
- ras_top  out  WIDTH  predicted return address (top entry; 0 when empty)
- ras_empty  out  1  stack count == 0
- ras_full  out  1  stack count == RAS_DEPTH
- mispredict  out  1  registered; ret occurred and prediction ≠ reg_target, or stack was empty
- misaligned  out  1  registered; selected target had nonzero low ALIGN_BITS bits

## Operation
- Next-PC priority, highest first: reset, stall (hold), jump_reg, jump, branch_taken, then pc_plus.
- Selected target with nonzero low ALIGN_BITS bits: PC loads the target with those bits forced to 0, and misaligned = 1 next cycle.
- RAS: circular buffer with top pointer and count (0..RAS_DEPTH).
  - Push (link, not stall): write pc_plus at top+1, advance top, count++ saturating at RAS_DEPTH. When full, the push overwrites the oldest entry (wrap).
  - Pop (ret, not stall, count > 0): top--, count--.
  - Pop when empty: no pointer change, and mispredict = 1.
  - link and ret together: top entry is replaced with pc_plus; pointer and count are unchanged. Prediction is compared against the pre-update top.
- mispredict = 1 next cycle when ret && (ras_empty || ras_top ≠ reg_target). The PC always takes reg_target; the prediction is advisory only.
- ret without jump_reg: treated as a pop only, no PC effect, no mispredict.
- stall: freezes pc, the RAS, top and count. mispredict and misaligned are 0 the next cycle.

## Timing
- Reset values: pc = RESET_VECTOR, count = 0, top = 0, all RAS entries 0, mispredict = 0, misaligned = 0. Reset overrides stall and every other input in the same cycle.
- pc updates one cycle after the select inputs are sampled; the sequence is pc, then next value at the following edge.
- pc_plus, ras_top, ras_empty and ras_full are combinational from registered state, so they are valid in the same cycle as pc.
- mispredict and misaligned are single-cycle pulses, asserted in the cycle after the triggering event and cleared after that.
- Reset asserted mid-sequence empties the stack; entries pushed before reset are not recoverable.
- pc wrap at 2^WIDTH − 2^ALIGN_BITS: pc_plus = 0, and sequential fetch continues from 0.

## Test plan
- Reset, then 3 free cycles (WIDTH=32, RESET_VECTOR=0x100) -> pc = 0x100, 0x104, 0x108, 0x10C; ras_empty = 1.
- Same cycle jump_reg=1 (0x200), jump=1 (0x300), branch_taken=1 (0x400) -> pc = 0x200. Next cycle with jump and branch only -> pc = 0x300.
- stall=1 for 2 cycles with branch_taken=1 -> pc unchanged, RAS unchanged. Release stall -> pc = branch_target.
- RAS_DEPTH=4, 5 link pushes at pc 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full = 1, ras_top = 0x54. Four ret pops with matching reg_target -> mispredict never set. Fifth pop -> mispredict = 1, ras_empty = 1.
- ret with reg_target = 0x88 while ras_top = 0x84 -> pc = 0x88, mispredict pulses one cycle.
- branch_target = 0x103 -> pc = 0x100, misaligned = 1 for exactly one cycle. Reset asserted together with stall -> pc = RESET_VECTOR.
